// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction-fetch stage: bus structs, the IF/ID
// pipeline register layout and the fetch FSM encoding.
package common;
    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [31:0] inst_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        inst_t data;
    } ibus_resp_t;

    localparam addr_t PC_RESET = 64'h8000_0000;
endpackage

package temp_storage;
    import common::*;

    typedef struct packed {
        inst_t inst;
        addr_t inst_pc;
        logic  valid;
        word_t inst_counter;
    } if_id;
endpackage

package fetch_unit_pkg;
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC select: a redirect beats sequential advance, which beats holding.
module fetch_unit_pc_next
    import common::*;
(
    input  logic  redirect_valid,
    input  addr_t redirect_pc,
    input  logic  advance,
    input  addr_t pc_q,
    output addr_t pc_d
);
    always_comb begin
        if (redirect_valid)
            pc_d = redirect_pc;
        else if (advance)
            pc_d = pc_q + 64'd4;
        else
            pc_d = pc_q;
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction bus and fills
// the IF/ID register, with a one-entry skid for stalls and drop-on-redirect.
module fetch_unit
    import common::*;
    import temp_storage::*;
    import fetch_unit_pkg::*;
#(
    parameter addr_t PC_RESET = common::PC_RESET
) (
    input  logic       clk,
    input  logic       resetn,
    output ibus_req_t  ireq,
    input  ibus_resp_t iresp,
    input  logic       stall,
    input  logic       redirect_valid,
    input  addr_t      redirect_pc,
    output if_id       if_id_state
);
    fetch_state_t state_q, state_d;
    addr_t        pc_q, pc_d;
    word_t        cnt_q, cnt_d;
    ibus_req_t    ireq_q, ireq_d;
    if_id         if_id_q, if_id_d;
    inst_t        skid_inst_q, skid_inst_d;
    addr_t        skid_pc_q, skid_pc_d;
    logic         resp;
    logic         advance;
    logic         unused_addr_ok;

    // A response only counts against a request we actually have on the bus.
    assign resp           = ireq_q.valid & iresp.data_ok;
    assign advance        = (state_q == FETCH) & resp;
    assign unused_addr_ok = iresp.addr_ok;

    fetch_unit_pc_next u_pc_next (
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .advance        (advance),
        .pc_q           (pc_q),
        .pc_d           (pc_d)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ireq_d      = ireq_q;
        if_id_d     = if_id_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        if (redirect_valid) begin
            if_id_d.valid = 1'b0;
            skid_inst_d   = '0;
            skid_pc_d     = '0;
            // An outstanding request cannot be withdrawn; keep it on the bus and drop its data.
            if ((state_q == FETCH || state_q == DRAIN) && ireq_q.valid && !iresp.data_ok) begin
                state_d = DRAIN;
            end else begin
                state_d = FETCH;
                ireq_d  = '{valid: 1'b1, addr: redirect_pc};
            end
        end else begin
            case (state_q)
                FETCH: begin
                    if (resp) begin
                        if (!stall) begin
                            if_id_d = '{inst: iresp.data, inst_pc: pc_q, valid: 1'b1, inst_counter: cnt_q};
                            cnt_d   = cnt_q + 64'd1;
                            ireq_d  = '{valid: 1'b1, addr: pc_d};
                        end else begin
                            skid_inst_d  = iresp.data;
                            skid_pc_d    = pc_q;
                            state_d      = HOLD;
                            ireq_d.valid = 1'b0;
                        end
                    end else begin
                        ireq_d = '{valid: 1'b1, addr: pc_q};
                        if (!stall)
                            if_id_d.valid = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if_id_d = '{inst: skid_inst_q, inst_pc: skid_pc_q, valid: 1'b1, inst_counter: cnt_q};
                        cnt_d   = cnt_q + 64'd1;
                        state_d = FETCH;
                        ireq_d  = '{valid: 1'b1, addr: pc_q};
                    end
                end
                DRAIN: begin
                    if (!stall)
                        if_id_d.valid = 1'b0;
                    if (resp) begin
                        state_d = FETCH;
                        ireq_d  = '{valid: 1'b1, addr: pc_q};
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= FETCH;
            pc_q        <= PC_RESET;
            cnt_q       <= '0;
            ireq_q      <= '0;
            if_id_q     <= '0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            cnt_q       <= cnt_d;
            ireq_q      <= ireq_d;
            if_id_q     <= if_id_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign ireq        = ireq_q;
    assign if_id_state = if_id_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Random bus latency / stall / redirect stimulus against a transaction-level
// model: a queue of accepted instructions, a stale-response flag and a PC stream.
module tb_fetch_unit;
    import common::*;
    import temp_storage::*;

    logic       clk = 1'b0;
    logic       resetn;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    logic       stall;
    logic       redirect_valid;
    addr_t      redirect_pc;
    if_id       if_id_state;

    fetch_unit #(.PC_RESET(64'h8000_0000)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .ireq           (ireq),
        .iresp          (iresp),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_state    (if_id_state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic inst_t mem(input addr_t a);
        return a[31:0] ^ a[63:32] ^ 32'hDEAD_BEEF;
    endfunction

    // reference model state
    addr_t q[$];
    if_id  exp_ifid;
    word_t cnt;
    logic  stale;
    addr_t exp_fetch;
    int    delivered = 0;
    // bus model state
    logic  t_act;
    int    t_left;
    addr_t t_addr;

    task automatic reset_model();
        q.delete();
        exp_ifid  = '0;
        cnt       = '0;
        stale     = 1'b0;
        exp_fetch = 64'h8000_0000;
        t_act     = 1'b0;
        t_left    = 0;
        t_addr    = '0;
    endtask

    task automatic do_reset();
        resetn         = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        iresp          = '0;
        @(posedge clk); #1;
        chk("rst_req_valid", {63'd0, ireq.valid}, 64'd0);
        chk("rst_valid", {63'd0, if_id_state.valid}, 64'd0);
        chk("rst_inst", {32'd0, if_id_state.inst}, 64'd0);
        chk("rst_pc", if_id_state.inst_pc, 64'd0);
        chk("rst_cnt", if_id_state.inst_counter, 64'd0);
        resetn = 1'b1;
        reset_model();
        @(posedge clk); #1;
    endtask

    task automatic step();
        logic  dok;
        logic  rv;
        addr_t rpc;
        addr_t p;
        chk("valid", {63'd0, if_id_state.valid}, {63'd0, exp_ifid.valid});
        chk("inst", {32'd0, if_id_state.inst}, {32'd0, exp_ifid.inst});
        chk("inst_pc", if_id_state.inst_pc, exp_ifid.inst_pc);
        chk("inst_counter", if_id_state.inst_counter, exp_ifid.inst_counter);
        // a request is on the bus exactly when nothing is parked in the skid
        chk("req_valid", {63'd0, ireq.valid}, {63'd0, q.size() == 0});

        dok = 1'b0;
        if (ireq.valid) begin
            if (!t_act) begin
                t_act  = 1'b1;
                t_left = $urandom_range(0, 3);
                t_addr = ireq.addr;
                if (!stale)
                    chk("req_addr", ireq.addr, exp_fetch);
            end else begin
                chk("req_stable", ireq.addr, t_addr);
            end
            if (t_left == 0) begin
                dok   = 1'b1;
                t_act = 1'b0;
            end else begin
                t_left--;
            end
        end

        stall = ($urandom_range(0, 3) == 0);
        rv    = ($urandom_range(0, 9) == 0);
        if ($urandom_range(0, 7) == 0)
            rpc = 64'hFFFF_FFFF_FFFF_FFF8;
        else
            rpc = 64'h8000_0000 + 64'($urandom_range(0, 63)) * 64'd4;
        redirect_valid = rv;
        redirect_pc    = rpc;
        iresp.addr_ok  = ireq.valid;
        iresp.data_ok  = dok;
        iresp.data     = dok ? mem(t_addr) : inst_t'($urandom);

        if (rv) begin
            exp_ifid.valid = 1'b0;
            q.delete();
            stale     = ireq.valid && !dok;
            exp_fetch = rpc;
        end else begin
            if (dok) begin
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    q.push_back(t_addr);
                    exp_fetch = t_addr + 64'd4;
                end
            end
            if (!stall) begin
                if (q.size() != 0) begin
                    p        = q.pop_front();
                    exp_ifid = '{inst: mem(p), inst_pc: p, valid: 1'b1, inst_counter: cnt};
                    cnt      = cnt + 64'd1;
                    delivered++;
                end else begin
                    exp_ifid.valid = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        do_reset();
        repeat (3000) step();
        // land a reset while a dropped response is still outstanding
        for (int i = 0; i < 500 && !stale; i++) step();
        chk("found_drain", {63'd0, stale}, 64'd1);
        do_reset();
        repeat (1000) step();
        chk("progress", {63'd0, delivered >= 200}, 64'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage. Owns the PC, issues requests on the instruction bus, and registers each returned instruction into the `if_id` pipeline register consumed by the decode stage. It handles downstream stall with a one-entry skid buffer, and control-flow redirects with a discard of any in-flight response.

## Interface
Parameters:
- `PC_RESET`, `64'h8000_0000`, PC loaded on reset.

Ports:
- `clk`  in  1  core clock.
- `resetn`  in  1  reset; synchronous, active-low.
- `ireq`  out  `ibus_req_t`  instruction-bus request (`valid`, `addr`).
- `iresp`  in  `ibus_resp_t`  instruction-bus response (`addr_ok`, `data_ok`, `data[31:0]`).
- `stall`  in  1  decode cannot accept; `if_id_state` must hold.
- `redirect_valid`  in  1  taken branch/jump/trap from a later stage.
- `redirect_pc`  in  `addr_t`  redirect target.
- `if_id_state`  out  `if_id`  `inst`, `inst_pc`, `valid`, `inst_counter`.

## Operation
- State machine states:
  - `FETCH`: `ireq.valid`=1, `ireq.addr`=pc.
  - `HOLD`: skid buffer full, `ireq.valid`=0.
  - `DRAIN`: in-flight request must complete and be dropped.
- Request rule: `ireq.valid`/`ireq.addr` stay stable until `data_ok`. A request is never withdrawn; a redirect goes through `DRAIN` instead.
- `FETCH` transitions:
  - `data_ok` and !`stall`: `if_id`←{data, pc, 1, cnt}; cnt++; pc←pc+4; stay in `FETCH`.
  - `data_ok` and `stall`: skid←{data, pc}; pc←pc+4; go to `HOLD`.
- `HOLD` transition: !`stall` → `if_id`←skid; cnt++; go to `FETCH`.
- `DRAIN` transition: `data_ok` → drop data; go to `FETCH` (pc already holds the target).
- Redirect has the highest priority, in any state:
  - pc←`redirect_pc`.
  - `if_id.valid`←0; skid cleared.
  - Next state is `DRAIN` if in `FETCH` with no `data_ok` this cycle, or if already in `DRAIN` with no `data_ok` this cycle. Otherwise next state is `FETCH`; any `data_ok` data that cycle is discarded.
  - Redirect overrides `stall`.
- `stall` with no redirect: `if_id_state` unchanged, including `valid`.
- Empty pipeline: when !`stall`, no `data_ok`, `FETCH` state → `if_id.valid`←0 (bubble).
- `inst_counter`: 64-bit count of instructions delivered valid into `if_id`. It is not decremented on redirect. Wrap-around is modular.
- pc arithmetic: 64-bit, +4 modulo 2^64. No alignment check; `redirect_pc` is used as-is.

## Timing
- Reset (`resetn`=0 at a rising edge):
  - state=`FETCH`, pc=`PC_RESET`, cnt=0, skid empty.
  - `if_id_state`: all fields 0, `valid`=0.
  - `ireq.valid`=0 while `resetn`=0. The first request appears in the cycle after `resetn` is sampled 1.
  - Reset mid-`DRAIN` abandons the pending response; any late `data_ok` is the bus's responsibility.
- Latency: `data_ok` in cycle N → `if_id.valid`=1 in N+1.
- Throughput: with a same-cycle `data_ok`, the next request (pc+4) is on the bus in N+1, giving 1 instruction/cycle.
- Redirect in cycle N: `ireq.addr`=`redirect_pc` from N+1 if not draining. If draining, from the cycle after the dropped `data_ok`.
- `HOLD` release: `stall` falls in cycle M → buffered instruction appears in `if_id` at M+1, and a new request is issued at M+1.

## Structure
- Shared package `common`: `addr_t`, `word_t`, `inst_t`, `ibus_req_t`, `ibus_resp_t`, `PC_RESET` default constant.
- Shared package `temp_storage`: `if_id`.
- Local enum `fetch_state_t` {`FETCH`, `HOLD`, `DRAIN`}.
- One natural sub-module: `pc_next`, a combinational priority mux (redirect > +4 > hold).

## Test plan
- Reset then bus always `data_ok`=1 with data=pc[31:0] → `if_id` shows pcs 0x8000_0000, 0x8000_0004, … on consecutive cycles; `inst_counter` 0, 1, 2…
- Bus with 3-cycle `data_ok` latency → `ireq.addr` is stable for 3 cycles; `if_id.valid` is 1 for one cycle per fetch; bubbles in between.
- `stall`=1 for 4 cycles arriving concurrently with `data_ok` → `if_id` frozen; `ireq.valid`=0 in `HOLD`. After release, the buffered inst at 0x…04 appears, then 0x…08. No loss or duplication.
- `redirect_valid`=1, `redirect_pc`=0x8000_0100, while a request to 0x…08 is pending 2 more cycles → the 0x…08 data is dropped; the next `ireq.addr`=0x8000_0100; `if_id.valid`=0 until that data returns.
- Redirect in the same cycle as `data_ok` and `stall`=1 → data and skid discarded; `if_id.valid`=0 next cycle; fetch resumes at the target.
- `resetn`=0 asserted during `DRAIN` → next cycle all outputs at reset values, pc=0x8000_0000.
